elastic_pipe_stage: RTL and testbench
=====================================

# elastic_pipe_stage

Parametrised, handshaked pipeline register that replaces the fixed-field, enable-driven inter-stage latches with one generic stage. It carries an opaque `DATA_WIDTH` payload between two pipeline stages using valid/ready flow control, synchronous flush, and an optional skid entry. The skid entry sustains one transfer per cycle while presenting a registered `in_ready` upstream. Instances sit between every pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB); each instance packs its stage fields into `in_data`.

## Interface
Parameters:
- `DATA_WIDTH`, 32: payload width in bits; must be ≥1.
- `RESET_VAL`, '0: value loaded into every data register on reset and on flush.

Ports:
- `CLK`  input  1  clock; all state updates on the rising edge.
- `nRST`  input  1  asynchronous, active-low reset.
- `flush`  input  1  synchronous squash of all held entries.
- `in_valid`  input  1  upstream presents `in_data`.
- `in_ready`  output  1  stage accepts `in_data` this cycle.
- `in_data`  input  DATA_WIDTH  upstream payload.
- `out_valid`  output  1  `out_data` holds a live entry.
- `out_ready`  input  1  downstream consumes `out_data` this cycle.
- `out_data`  output  DATA_WIDTH  head entry payload.
- `occupancy`  output  2  number of live entries: 0, 1 or 2.

## Operation
- in_fire = `in_valid & in_ready`; out_fire = `out_valid & out_ready`.
- Storage is a main register and a skid register. `out_data` is always the main register.
- States: EMPTY (occ 0), BUSY (main live, occ 1), FULL (main and skid live, occ 2).
- EMPTY: on in_fire, main <= `in_data` and state goes to BUSY.
- BUSY:
  - in_fire & out_fire: main <= `in_data`; stays BUSY.
  - in_fire & !out_fire: skid <= `in_data`; goes to FULL.
  - out_fire only: goes to EMPTY. Main keeps its stale value.
- FULL: `in_ready`=0. On out_fire, main <= skid and state goes to BUSY.
- `out_valid` = (state != EMPTY). `in_ready` = (state != FULL), decoded from the state flops only, with no combinational path from `out_ready`.
- Flush has top priority:
  - Next state is EMPTY; main and skid <= `RESET_VAL`.
  - An in_fire or out_fire in the flush cycle still completes its handshake. The accepted payload is discarded.
- Ordering is strict FIFO. No entry is duplicated or dropped except by flush.
- `out_data` is meaningful only while `out_valid`=1. It equals `RESET_VAL` after reset or flush until the first load.

## Timing
- Reset (async, `nRST`=0): state EMPTY, `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_data`=`RESET_VAL`. Release takes effect at the next edge.
- Latency: `in_data` accepted at edge N appears on `out_data` with `out_valid`=1 after edge N, i.e. one cycle.
- Throughput: one transfer per cycle when `out_ready`=1 continuously.
- Backpressure: after `out_ready` falls, at most one more entry is accepted, into the skid register. `in_ready` falls at the edge that fills the skid.
- Recovery: `in_ready` rises at the edge where FULL drains to BUSY.
- Reset asserted mid-transfer: all entries are lost immediately; no partial state survives.

## Configuration
- `ELASTIC_PIPE_SKID_EN` defined: two-entry behaviour as above, with registered `in_ready`.
- `ELASTIC_PIPE_SKID_EN` undefined:
  - No skid register and no FULL state; `occupancy` ≤ 1.
  - `in_ready` = `!out_valid | out_ready`, a combinational path.
  - In BUSY, in_fire & out_fire reloads main. Flush and reset rules are unchanged.

## Test plan
- Reset with `RESET_VAL`=32'hDEAD_BEEF → `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_data`=32'hDEADBEEF.
- Stream 0x1..0x8 with `out_ready`=1 throughout → outputs 0x1..0x8 on consecutive cycles, one cycle after each input, `occupancy` constant at 1.
- Stream 0x10, 0x11, 0x12 with `out_ready`=0 (skid enabled) → 0x10 and 0x11 held, `occupancy`=2, `in_ready`=0. 0x12 is stalled at the source and not accepted. Raising `out_ready` drains 0x10, 0x11, then 0x12 in order.
- In FULL, assert `flush` together with `out_ready`=1 → next cycle `occupancy`=0, `out_valid`=0, `out_data`=`RESET_VAL`, and no stale 0x11 emerges.
- Pull `nRST` low asynchronously in BUSY between edges → `out_valid` drops immediately, before the next edge.
- Macro undefined, BUSY with 0x20, `out_ready`=1 and `in_valid`=1 with 0x21 in the same cycle → `in_ready`=1 that cycle, and 0x21 is on the output next cycle.

Source files
------------

// File: rtl/elastic_pipe_stage.sv
// Purpose : generic valid/ready pipeline register with synchronous flush and optional skid entry.
// Latency : one cycle from in_data acceptance to out_data/out_valid.
// Backpr. : skid build accepts one more beat after out_ready drops, then in_ready falls (registered);
//           non-skid build stalls combinationally (in_ready = !out_valid | out_ready).
//
// Build option: ELASTIC_PIPE_SKID_EN (defined = two-entry stage with skid register and FULL state).
//
// Ports:
//   CLK        rising-edge clock
//   nRST       asynchronous active-low reset
//   flush      synchronous squash of all held entries (top priority)
//   in_valid   upstream presents in_data
//   in_ready   stage accepts in_data this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a live entry
//   out_ready  downstream consumes out_data this cycle
//   out_data   head entry payload (main register)
//   occupancy  live entries: 0, 1 or 2
module elastic_pipe_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] w_main_nxt;
  logic                  w_in_fire;
  logic                  w_out_fire;

  assign out_valid  = (r_state != ST_EMPTY);
  assign out_data   = r_main;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

`ifdef ELASTIC_PIPE_SKID_EN
  logic [DATA_WIDTH-1:0] r_skid;
  logic [DATA_WIDTH-1:0] w_skid_nxt;

  // Decoded from the state flops only, so upstream never sees out_ready combinationally.
  assign in_ready = (r_state != ST_FULL);

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      // Handshakes in this cycle still complete; the accepted payload is simply dropped.
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = RESET_VAL;
      w_skid_nxt  = RESET_VAL;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_main_nxt  = in_data;
            w_state_nxt = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = in_data;
          end else if (w_in_fire) begin
            // Downstream stalled: park the extra beat behind the head.
            w_skid_nxt  = in_data;
            w_state_nxt = ST_FULL;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;  // main keeps its stale value
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_main_nxt  = r_skid;
            w_state_nxt = ST_BUSY;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_skid <= RESET_VAL;
    end else begin
      r_skid <= w_skid_nxt;
    end
  end
`else
  // Single entry: a consuming downstream frees the slot in the same cycle.
  assign in_ready = !out_valid | out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = RESET_VAL;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_main_nxt  = in_data;
            w_state_nxt = ST_BUSY;
          end
        end
        ST_BUSY: begin
          // in_fire here implies out_fire, since in_ready needs out_ready while BUSY.
          if (w_in_fire) begin
            w_main_nxt = in_data;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_EMPTY;
      r_main  <= RESET_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
    end
  end

  always_comb begin
    occupancy = 2'd0;
    case (r_state)
      ST_BUSY: occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_elastic_pipe_stage.sv
module tb_elastic_pipe_stage;

  localparam int          W    = 32;
  localparam logic [31:0] RVAL = 32'hDEAD_BEEF;
`ifdef ELASTIC_PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         CLK;
  logic         nRST;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  elastic_pipe_stage #(.DATA_WIDTH(W), .RESET_VAL(RVAL)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: scoreboard queue of live entries plus the expected main register.
  logic [W-1:0] sb_q[$];
  logic [W-1:0] exp_main;

  typedef struct {
    logic         vld;
    logic [W-1:0] dat;
    logic         ordy;
    logic         fl;
    logic [1:0]   e_occ;
    logic         e_ovld;
    logic         e_irdy;
    logic [W-1:0] e_odat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    if (SKID) return (sb_q.size() < 2);
    return (sb_q.size() == 0) || out_ready;
  endfunction

  // Drive inputs, then compare DUT outputs with the model at the falling edge.
  task automatic pre(input logic vld, input logic [W-1:0] dat, input logic ordy, input logic fl);
    in_valid  = vld;
    in_data   = dat;
    out_ready = ordy;
    flush     = fl;
    @(negedge CLK);
    chk("sb_out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() != 0});
    chk("sb_in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
    chk("sb_occupancy", {30'd0, occupancy}, sb_q.size());
    chk("sb_out_data", out_data, exp_main);
  endtask

  // Clock edge: advance the model using its own view of the handshake.
  task automatic post();
    logic ifire;
    logic ofire;
    ifire = in_valid & model_ready();
    ofire = (sb_q.size() != 0) & out_ready;
    @(posedge CLK);
    if (flush) begin
      sb_q.delete();
      exp_main = RVAL;
    end else begin
      if (ofire) void'(sb_q.pop_front());
      if (ifire) sb_q.push_back(in_data);
      if (sb_q.size() != 0) exp_main = sb_q[0];
    end
    #1;
  endtask

  task automatic step(input logic vld, input logic [W-1:0] dat, input logic ordy, input logic fl);
    pre(vld, dat, ordy, fl);
    post();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Streaming vectors with out_ready high; expectations are pre-edge outputs.
    for (int i = 0; i < 8; i++) begin
      tbl[i].vld    = 1'b1;
      tbl[i].dat    = i + 1;
      tbl[i].ordy   = 1'b1;
      tbl[i].fl     = 1'b0;
      tbl[i].e_occ  = (i == 0) ? 2'd0 : 2'd1;
      tbl[i].e_ovld = (i != 0);
      tbl[i].e_irdy = 1'b1;
      tbl[i].e_odat = (i == 0) ? RVAL : i;
    end
    tbl[8] = '{1'b0, 32'd0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'd8};
    tbl[9] = '{1'b0, 32'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'd8};

    flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    exp_main = RVAL;
    nRST = 1'b1;
    #1 nRST = 1'b0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
    chk("rst_out_data", out_data, RVAL);
    @(posedge CLK);
    @(negedge CLK) nRST = 1'b1;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 10; i++) begin
      pre(tbl[i].vld, tbl[i].dat, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("tbl%0d_occ", i), {30'd0, occupancy}, {30'd0, tbl[i].e_occ});
      chk($sformatf("tbl%0d_ovld", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ovld});
      chk($sformatf("tbl%0d_irdy", i), {31'd0, in_ready}, {31'd0, tbl[i].e_irdy});
      chk($sformatf("tbl%0d_odat", i), out_data, tbl[i].e_odat);
      post();
    end

`ifdef ELASTIC_PIPE_SKID_EN
    // Backpressure: two beats held, third stalled at the source.
    step(1'b1, 32'h10, 1'b0, 1'b0);
    step(1'b1, 32'h11, 1'b0, 1'b0);
    pre(1'b1, 32'h12, 1'b0, 1'b0);
    chk("skid_occ_full", {30'd0, occupancy}, 32'd2);
    chk("skid_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("skid_head", out_data, 32'h10);
    post();
    pre(1'b1, 32'h12, 1'b1, 1'b0);
    chk("drain_0", out_data, 32'h10);
    post();
    pre(1'b1, 32'h12, 1'b1, 1'b0);
    chk("drain_1", out_data, 32'h11);
    chk("drain_1_irdy", {31'd0, in_ready}, 32'd1);
    post();
    pre(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain_2", out_data, 32'h12);
    post();
    // Flush while FULL with out_ready high.
    step(1'b1, 32'h10, 1'b0, 1'b0);
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("flush_occ", {30'd0, occupancy}, 32'd0);
    chk("flush_ovld", {31'd0, out_valid}, 32'd0);
    chk("flush_odat", out_data, RVAL);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("flush_no_stale", {31'd0, out_valid}, 32'd0);
    end
`else
    // Same-cycle reload from BUSY.
    step(1'b1, 32'h20, 1'b1, 1'b0);
    pre(1'b1, 32'h21, 1'b1, 1'b0);
    chk("ns_in_ready_reload", {31'd0, in_ready}, 32'd1);
    chk("ns_head_20", out_data, 32'h20);
    post();
    chk("ns_next_21", out_data, 32'h21);
    // Stall: in_ready follows out_ready combinationally.
    pre(1'b1, 32'h22, 1'b0, 1'b0);
    chk("ns_in_ready_stall", {31'd0, in_ready}, 32'd0);
    post();
    chk("ns_occ_max1", {30'd0, occupancy}, 32'd1);
    chk("ns_hold_21", out_data, 32'h21);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("ns_flush_occ", {30'd0, occupancy}, 32'd0);
    chk("ns_flush_odat", out_data, RVAL);
`endif

    // Accept in the flush cycle: the payload is discarded.
    step(1'b1, 32'h30, 1'b1, 1'b1);
    chk("flush_accept_drop", {31'd0, out_valid}, 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Stale main after drain, then async reset mid-cycle while BUSY.
    step(1'b1, 32'h40, 1'b0, 1'b0);
    chk("busy_before_rst", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    #2 nRST = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_occ", {30'd0, occupancy}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_odat", out_data, RVAL);
    sb_q.delete();
    exp_main = RVAL;
    @(negedge CLK) nRST = 1'b1;
    @(posedge CLK);
    #1;
    step(1'b1, 32'h50, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("post_rst_stale", out_data, 32'h50);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
